// File: rtl/rsp_seq_if.sv
// Link between the response sequencer and the CMD-line response receiver.
// The sequencer arms the receiver, tells it the expected length and forces
// it inactive on timeout/abort. The receiver reports the start bit, the
// finished response and its status.
interface rsp_seq_if #(
    parameter int RspWidth = 120
);
    logic                receiving_i;
    logic                rsp_valid_i;
    logic                rsp_end_bit_err_i;
    logic                rsp_crc_corr_i;
    logic [RspWidth-1:0] rsp_i;
    logic                start_listening_o;
    logic                long_rsp_o;
    logic                timeout_o;

    // Sequencer side
    modport master (
        input  receiving_i,
        input  rsp_valid_i,
        input  rsp_end_bit_err_i,
        input  rsp_crc_corr_i,
        input  rsp_i,
        output start_listening_o,
        output long_rsp_o,
        output timeout_o
    );

    // Receiver side
    modport slave (
        output receiving_i,
        output rsp_valid_i,
        output rsp_end_bit_err_i,
        output rsp_crc_corr_i,
        output rsp_i,
        input  start_listening_o,
        input  long_rsp_o,
        input  timeout_o
    );
endinterface

// File: rtl/rsp_seq.sv
// Response sequencer for the CMD line. Per issued command it decides whether
// a response is expected and how long it is, arms the receiver two clk_i
// cycles after the command end bit, enforces the Ncr timeout, latches the
// payload and turns the receiver status into one-cycle completion/error
// pulses for the interrupt status logic.
module rsp_seq #(
    parameter int TimeoutTicks = 64,
    parameter int RspWidth     = 120
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clk_en_i,
    input  logic                cmd_issue_i,
    input  logic [1:0]          rsp_type_i,
    input  logic [5:0]          cmd_index_i,
    input  logic                crc_check_en_i,
    input  logic                index_check_en_i,
    input  logic                cmd_end_i,
    input  logic                abort_i,
    rsp_seq_if.master           rx,
    output logic                cmd_inhibit_o,
    output logic [RspWidth-1:0] rsp_o,
    output logic                rsp_wr_o,
    output logic                cmd_complete_o,
    output logic                crc_err_o,
    output logic                end_bit_err_o,
    output logic                index_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_END,
        S_GAP,
        S_LISTEN,
        S_RECEIVE,
        S_REPORT
    } state_t;

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_R2   = 2'b01;
    // Tick that brings the counter up to TimeoutTicks
    localparam logic [7:0] TO_LAST   = 8'(TimeoutTicks - 1);

    state_t              state_q, state_d;
    logic [1:0]          type_q, type_d;
    logic [5:0]          idx_q, idx_d;
    logic                crc_en_q, crc_en_d;
    logic                idx_en_q, idx_en_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                to_q, to_d;
    logic                crc_bad_q, crc_bad_d;
    logic                ebe_q, ebe_d;
    logic                idx_bad_q, idx_bad_d;
    logic [RspWidth-1:0] rsp_q, rsp_d;
    logic                rsp_wr_q, rsp_wr_d;
    logic                sl_q, sl_d;
    logic                to_pulse;
    logic                report_ok;

    // State and captured-field registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            type_q    <= '0;
            idx_q     <= '0;
            crc_en_q  <= 1'b0;
            idx_en_q  <= 1'b0;
            cnt_q     <= '0;
            to_q      <= 1'b0;
            crc_bad_q <= 1'b0;
            ebe_q     <= 1'b0;
            idx_bad_q <= 1'b0;
            rsp_q     <= '0;
            rsp_wr_q  <= 1'b0;
            sl_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            idx_q     <= idx_d;
            crc_en_q  <= crc_en_d;
            idx_en_q  <= idx_en_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            crc_bad_q <= crc_bad_d;
            ebe_q     <= ebe_d;
            idx_bad_q <= idx_bad_d;
            rsp_q     <= rsp_d;
            rsp_wr_q  <= rsp_wr_d;
            sl_q      <= sl_d;
        end
    end

    // Next-state logic, field capture, tick counting and timeout detection
    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        idx_d     = idx_q;
        crc_en_d  = crc_en_q;
        idx_en_d  = idx_en_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        crc_bad_d = crc_bad_q;
        ebe_d     = ebe_q;
        idx_bad_d = idx_bad_q;
        rsp_d     = rsp_q;
        rsp_wr_d  = 1'b0;
        sl_d      = 1'b0;
        to_pulse  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_issue_i) begin
                    type_d    = rsp_type_i;
                    idx_d     = cmd_index_i;
                    crc_en_d  = crc_check_en_i;
                    idx_en_d  = index_check_en_i;
                    // Stale flags must not leak into a no-response REPORT
                    to_d      = 1'b0;
                    crc_bad_d = 1'b0;
                    ebe_d     = 1'b0;
                    idx_bad_d = 1'b0;
                    state_d   = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (cmd_end_i) begin
                    state_d = (type_q == TYPE_NONE) ? S_REPORT : S_GAP;
                end
            end
            S_GAP: begin
                // Registered so the arm pulse lands on the first LISTEN cycle,
                // the 2nd clk_i cycle after the end bit
                sl_d    = 1'b1;
                cnt_d   = '0;
                state_d = S_LISTEN;
            end
            S_LISTEN: begin
                // A start bit in the same cycle as the final tick wins
                if (rx.receiving_i) begin
                    state_d = S_RECEIVE;
                end else if (clk_en_i) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == TO_LAST) begin
                        to_pulse = 1'b1;
                        to_d     = 1'b1;
                        state_d  = S_REPORT;
                    end
                end
            end
            S_RECEIVE: begin
                if (rx.rsp_valid_i) begin
                    rsp_d     = rx.rsp_i;
                    rsp_wr_d  = 1'b1;
                    crc_bad_d = crc_en_q & ~rx.rsp_crc_corr_i;
                    ebe_d     = rx.rsp_end_bit_err_i;
                    // R2 carries no command index field
                    idx_bad_d = idx_en_q & (type_q != TYPE_R2) &
                                (rx.rsp_i[37:32] != idx_q);
                    state_d   = S_REPORT;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything: back to IDLE, payload untouched, and a
        // timeout pulse if the receiver might be active
        if (abort_i) begin
            state_d  = S_IDLE;
            rsp_d    = rsp_q;
            rsp_wr_d = 1'b0;
            sl_d     = 1'b0;
            to_pulse = (state_q == S_LISTEN) || (state_q == S_RECEIVE);
        end
    end

    assign report_ok = (state_q == S_REPORT) && !to_q && !abort_i;

    assign rx.start_listening_o = sl_q;
    assign rx.long_rsp_o        = (state_q != S_IDLE) && (type_q == TYPE_R2);
    assign rx.timeout_o         = to_pulse;
    assign cmd_inhibit_o        = (state_q != S_IDLE);
    assign rsp_o                = rsp_q;
    assign rsp_wr_o             = rsp_wr_q;
    assign cmd_complete_o       = report_ok;
    assign crc_err_o            = report_ok & crc_bad_q;
    assign end_bit_err_o        = report_ok & ebe_q;
    assign index_err_o          = report_ok & idx_bad_q;

endmodule

// File: tb/tb_rsp_seq.sv
// Directed self-checking bench for the CMD-line response sequencer.
module tb_rsp_seq;
    localparam int RW = 120;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          clk_en_i;
    logic          cmd_issue_i;
    logic [1:0]    rsp_type_i;
    logic [5:0]    cmd_index_i;
    logic          crc_check_en_i;
    logic          index_check_en_i;
    logic          cmd_end_i;
    logic          abort_i;
    logic          cmd_inhibit_o;
    logic [RW-1:0] rsp_o;
    logic          rsp_wr_o;
    logic          cmd_complete_o;
    logic          crc_err_o;
    logic          end_bit_err_o;
    logic          index_err_o;

    int checks = 0;
    int errors = 0;

    rsp_seq_if #(.RspWidth(RW)) rif ();

    rsp_seq #(.TimeoutTicks(64), .RspWidth(RW)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .clk_en_i         (clk_en_i),
        .cmd_issue_i      (cmd_issue_i),
        .rsp_type_i       (rsp_type_i),
        .cmd_index_i      (cmd_index_i),
        .crc_check_en_i   (crc_check_en_i),
        .index_check_en_i (index_check_en_i),
        .cmd_end_i        (cmd_end_i),
        .abort_i          (abort_i),
        .rx               (rif.master),
        .cmd_inhibit_o    (cmd_inhibit_o),
        .rsp_o            (rsp_o),
        .rsp_wr_o         (rsp_wr_o),
        .cmd_complete_o   (cmd_complete_o),
        .crc_err_o        (crc_err_o),
        .end_bit_err_o    (end_bit_err_o),
        .index_err_o      (index_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Payloads: 48-bit responses carry index in [37:32], argument in [31:0]
    logic [RW-1:0] r_ok;
    logic [RW-1:0] r_bad;
    logic [RW-1:0] r_r2;
    logic [RW-1:0] r_other;
    logic [RW-1:0] last_rsp;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [5:0] idx,
                         input logic ce, input logic ie);
        rsp_type_i       = t;
        cmd_index_i      = idx;
        crc_check_en_i   = ce;
        index_check_en_i = ie;
        cmd_issue_i      = 1'b1;
        cyc();
        cmd_issue_i      = 1'b0;
    endtask

    // From WAIT_END to the first LISTEN cycle
    task automatic to_listen();
        cmd_end_i = 1'b1;
        cyc();
        cmd_end_i = 1'b0;
        cyc();
    endtask

    // From WAIT_END into RECEIVE
    task automatic to_receive();
        to_listen();
        rif.receiving_i = 1'b1;
        cyc();
        rif.receiving_i = 1'b0;
    endtask

    task automatic send_rsp(input logic [RW-1:0] v, input logic crc_ok,
                            input logic ebe);
        rif.rsp_i             = v;
        rif.rsp_crc_corr_i    = crc_ok;
        rif.rsp_end_bit_err_i = ebe;
        rif.rsp_valid_i       = 1'b1;
        cyc();
        rif.rsp_valid_i       = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
        cyc();
        checks++;
        if ({rif.start_listening_o, rif.long_rsp_o, rif.timeout_o, cmd_inhibit_o, rsp_wr_o,
             cmd_complete_o, crc_err_o, end_bit_err_o, index_err_o} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 000000000",
                     {rif.start_listening_o, rif.long_rsp_o, rif.timeout_o, cmd_inhibit_o,
                      rsp_wr_o, cmd_complete_o, crc_err_o, end_bit_err_o, index_err_o});
        end
        checks++;
        if (rsp_o !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got %h required 0", rsp_o);
        end
    endtask

    task automatic test_basic();
        issue(2'b10, 6'd17, 1'b1, 1'b1);
        checks++;
        if ({cmd_inhibit_o, rif.long_rsp_o} !== 2'b10) begin
            errors++;
            $display("FAIL basic_inhibit: got %b required 10", {cmd_inhibit_o, rif.long_rsp_o});
        end
        cmd_end_i = 1'b1;
        cyc();
        cmd_end_i = 1'b0;
        checks++;
        if (rif.start_listening_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_sl_early: got %b required 0", rif.start_listening_o);
        end
        cyc();
        checks++;
        if (rif.start_listening_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_sl_2nd: got %b required 1", rif.start_listening_o);
        end
        cyc();
        checks++;
        if (rif.start_listening_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_sl_width: got %b required 0", rif.start_listening_o);
        end
        rif.receiving_i = 1'b1;
        cyc();
        rif.receiving_i       = 1'b0;
        rif.rsp_i             = r_ok;
        rif.rsp_crc_corr_i    = 1'b1;
        rif.rsp_end_bit_err_i = 1'b0;
        rif.rsp_valid_i       = 1'b1;
        #1;
        checks++;
        if ({cmd_complete_o, rsp_wr_o, rif.timeout_o} !== 3'b000) begin
            errors++;
            $display("FAIL basic_receive: got %b required 000",
                     {cmd_complete_o, rsp_wr_o, rif.timeout_o});
        end
        cyc();
        rif.rsp_valid_i = 1'b0;
        checks++;
        if ({cmd_complete_o, crc_err_o, end_bit_err_o, index_err_o, rsp_wr_o, cmd_inhibit_o}
            !== 6'b100011) begin
            errors++;
            $display("FAIL basic_report: got %b required 100011",
                     {cmd_complete_o, crc_err_o, end_bit_err_o, index_err_o, rsp_wr_o,
                      cmd_inhibit_o});
        end
        checks++;
        if (rsp_o !== r_ok) begin
            errors++;
            $display("FAIL basic_rsp: got %h required %h", rsp_o, r_ok);
        end
        cyc();
        checks++;
        if ({cmd_inhibit_o, cmd_complete_o, rsp_wr_o} !== 3'b000) begin
            errors++;
            $display("FAIL basic_idle: got %b required 000",
                     {cmd_inhibit_o, cmd_complete_o, rsp_wr_o});
        end
    endtask

    task automatic test_r2();
        issue(2'b01, 6'd17, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cmd_end_i       = (i == 0);
            rif.receiving_i = (i == 2);
            #1;
            checks++;
            if (rif.long_rsp_o !== 1'b1) begin
                errors++;
                $display("FAIL r2_long_seq%0d: got %b required 1", i, rif.long_rsp_o);
            end
            cyc();
        end
        cmd_end_i       = 1'b0;
        rif.receiving_i = 1'b0;
        send_rsp(r_r2, 1'b1, 1'b0);
        checks++;
        if ({rif.long_rsp_o, cmd_complete_o, crc_err_o, end_bit_err_o, index_err_o, rsp_wr_o}
            !== 6'b110001) begin
            errors++;
            $display("FAIL r2_report: got %b required 110001",
                     {rif.long_rsp_o, cmd_complete_o, crc_err_o, end_bit_err_o, index_err_o,
                      rsp_wr_o});
        end
        checks++;
        if (rsp_o !== r_r2) begin
            errors++;
            $display("FAIL r2_rsp: got %h required %h", rsp_o, r_r2);
        end
        cyc();
        checks++;
        if (rif.long_rsp_o !== 1'b0) begin
            errors++;
            $display("FAIL r2_long_idle: got %b required 0", rif.long_rsp_o);
        end
    endtask

    task automatic test_timeout();
        for (int rep = 0; rep < 2; rep++) begin
            issue(2'b10, 6'd17, 1'b1, 1'b1);
            to_listen();
            for (int t = 1; t <= 64; t++) begin
                clk_en_i = 1'b0;
                cyc();
                cyc();
                clk_en_i = 1'b1;
                #1;
                checks++;
                if (rif.timeout_o !== (t == 64)) begin
                    errors++;
                    $display("FAIL timeout_tick%0d_rep%0d: got %b required %b",
                             t, rep, rif.timeout_o, (t == 64));
                end
                cyc();
            end
            clk_en_i = 1'b0;
            checks++;
            if ({rif.timeout_o, cmd_complete_o, crc_err_o, end_bit_err_o, index_err_o,
                 rsp_wr_o, cmd_inhibit_o} !== 7'b0000001) begin
                errors++;
                $display("FAIL timeout_report_rep%0d: got %b required 0000001", rep,
                         {rif.timeout_o, cmd_complete_o, crc_err_o, end_bit_err_o,
                          index_err_o, rsp_wr_o, cmd_inhibit_o});
            end
            cyc();
            checks++;
            if ({cmd_inhibit_o, rif.timeout_o} !== 2'b00) begin
                errors++;
                $display("FAIL timeout_idle_rep%0d: got %b required 00", rep,
                         {cmd_inhibit_o, rif.timeout_o});
            end
        end
    endtask

    task automatic test_errors();
        for (int k = 0; k < 2; k++) begin
            logic ce;
            ce = (k == 0);
            issue(2'b10, 6'd17, ce, 1'b1);
            to_receive();
            send_rsp(r_bad, 1'b0, 1'b1);
            checks++;
            if ({cmd_complete_o, crc_err_o, end_bit_err_o, index_err_o, rsp_wr_o}
                !== {1'b1, ce, 3'b111}) begin
                errors++;
                $display("FAIL errors_crcen%0b: got %b required %b", ce,
                         {cmd_complete_o, crc_err_o, end_bit_err_o, index_err_o, rsp_wr_o},
                         {1'b1, ce, 3'b111});
            end
            cyc();
        end
    endtask

    task automatic test_none();
        issue(2'b00, 6'd5, 1'b1, 1'b1);
        cmd_end_i = 1'b1;
        #1;
        checks++;
        if ({cmd_inhibit_o, rif.start_listening_o} !== 2'b10) begin
            errors++;
            $display("FAIL none_wait: got %b required 10", {cmd_inhibit_o, rif.start_listening_o});
        end
        cyc();
        cmd_end_i = 1'b0;
        checks++;
        if ({cmd_complete_o, crc_err_o, end_bit_err_o, index_err_o, rsp_wr_o,
             rif.start_listening_o} !== 6'b100000) begin
            errors++;
            $display("FAIL none_report: got %b required 100000",
                     {cmd_complete_o, crc_err_o, end_bit_err_o, index_err_o, rsp_wr_o,
                      rif.start_listening_o});
        end
        cyc();
        checks++;
        if ({cmd_complete_o, rif.start_listening_o, cmd_inhibit_o} !== 3'b000) begin
            errors++;
            $display("FAIL none_idle: got %b required 000",
                     {cmd_complete_o, rif.start_listening_o, cmd_inhibit_o});
        end
    endtask

    task automatic test_abort();
        last_rsp = rsp_o;
        issue(2'b10, 6'd17, 1'b1, 1'b1);
        to_listen();
        abort_i = 1'b1;
        #1;
        checks++;
        if ({rif.timeout_o, cmd_complete_o} !== 2'b10) begin
            errors++;
            $display("FAIL abort_listen: got %b required 10", {rif.timeout_o, cmd_complete_o});
        end
        cyc();
        abort_i = 1'b0;
        checks++;
        if ({cmd_inhibit_o, rif.timeout_o, cmd_complete_o, rsp_wr_o} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_idle: got %b required 0000",
                     {cmd_inhibit_o, rif.timeout_o, cmd_complete_o, rsp_wr_o});
        end
        issue(2'b10, 6'd17, 1'b1, 1'b1);
        checks++;
        if (cmd_inhibit_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_reissue: got %b required 1", cmd_inhibit_o);
        end
        // Abort while still waiting for the end bit: receiver never armed
        abort_i = 1'b1;
        #1;
        checks++;
        if (rif.timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait_end: got %b required 0", rif.timeout_o);
        end
        cyc();
        abort_i = 1'b0;
        // Abort in RECEIVE coincident with a finished response
        issue(2'b10, 6'd17, 1'b1, 1'b1);
        to_receive();
        abort_i = 1'b1;
        rif.rsp_i = r_other;
        rif.rsp_valid_i = 1'b1;
        #1;
        checks++;
        if (rif.timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_receive_to: got %b required 1", rif.timeout_o);
        end
        cyc();
        abort_i = 1'b0;
        rif.rsp_valid_i = 1'b0;
        checks++;
        if ({cmd_inhibit_o, cmd_complete_o, rsp_wr_o} !== 3'b000 || rsp_o !== last_rsp) begin
            errors++;
            $display("FAIL abort_receive: got %b/%h required 000/%h",
                     {cmd_inhibit_o, cmd_complete_o, rsp_wr_o}, rsp_o, last_rsp);
        end
    endtask

    task automatic test_ignored();
        last_rsp = rsp_o;
        cmd_end_i = 1'b1;
        rif.rsp_i = r_other;
        rif.rsp_valid_i = 1'b1;
        cyc();
        cmd_end_i = 1'b0;
        checks++;
        if ({cmd_inhibit_o, rsp_wr_o, cmd_complete_o} !== 3'b000 || rsp_o !== last_rsp) begin
            errors++;
            $display("FAIL ignored_idle: got %b/%h required 000/%h",
                     {cmd_inhibit_o, rsp_wr_o, cmd_complete_o}, rsp_o, last_rsp);
        end
        rif.rsp_valid_i = 1'b0;
        issue(2'b10, 6'd17, 1'b1, 1'b1);
        to_listen();
        // Valid without a start bit, and a second issue, must both be ignored
        rif.rsp_valid_i = 1'b1;
        rsp_type_i = 2'b01;
        cmd_issue_i = 1'b1;
        cyc();
        rif.rsp_valid_i = 1'b0;
        cmd_issue_i = 1'b0;
        checks++;
        if ({rif.long_rsp_o, rsp_wr_o, cmd_complete_o, cmd_inhibit_o} !== 4'b0001
            || rsp_o !== last_rsp) begin
            errors++;
            $display("FAIL ignored_listen: got %b/%h required 0001/%h",
                     {rif.long_rsp_o, rsp_wr_o, cmd_complete_o, cmd_inhibit_o}, rsp_o, last_rsp);
        end
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
    endtask

    task automatic test_async_reset();
        issue(2'b01, 6'd17, 1'b1, 1'b1);
        to_listen();
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({cmd_inhibit_o, rif.start_listening_o, rif.long_rsp_o} !== 3'b000 || rsp_o !== '0)
        begin
            errors++;
            $display("FAIL async_reset: got %b/%h required 000/0",
                     {cmd_inhibit_o, rif.start_listening_o, rif.long_rsp_o}, rsp_o);
        end
        #1;
        rst_i = 1'b0;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        r_ok    = {82'd0, 6'd17, 32'hDEADBEEF};
        r_bad   = {82'd0, 6'd18, 32'h12345678};
        r_r2    = 120'hA5F0_1234_5678_9ABC_DEF0_1357_9BDB_5A;
        r_other = {82'd0, 6'd3, 32'hCAFEF00D};
        rst_i = 1'b1;
        clk_en_i = 1'b0;
        cmd_issue_i = 1'b0;
        rsp_type_i = 2'b00;
        cmd_index_i = 6'd0;
        crc_check_en_i = 1'b0;
        index_check_en_i = 1'b0;
        cmd_end_i = 1'b0;
        abort_i = 1'b0;
        rif.receiving_i = 1'b0;
        rif.rsp_valid_i = 1'b0;
        rif.rsp_end_bit_err_i = 1'b0;
        rif.rsp_crc_corr_i = 1'b0;
        rif.rsp_i = '0;

        test_reset();
        test_basic();
        test_r2();
        test_timeout();
        test_errors();
        test_none();
        test_abort();
        test_ignored();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rsp_seq.md
Name: rsp_seq

Overview:
- Sequencer for the CMD-line response receiver; sits between the command issue path and the response receiver.
- Per issued command, decides whether a response is expected and its length. Arms the receiver on the 2nd clk_i cycle after the command end bit.
- Enforces the Ncr response timeout and latches the 120-bit payload. Converts receiver status into one-cycle completion and error pulses for the interrupt status logic.

Parameters:
- TimeoutTicks, 64, number of clk_en_i ticks without a start bit before timeout (Ncr).
- RspWidth, 120, payload width taken from the receiver.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- clk_en_i  in  1  SD-clock tick; one clk_i cycle wide
- cmd_issue_i  in  1  pulse: command accepted for transmission
- rsp_type_i  in  2  sampled at cmd_issue_i: 00 none, 01 136-bit (R2), 10 48-bit, 11 48-bit with busy
- cmd_index_i  in  6  sampled at cmd_issue_i
- crc_check_en_i  in  1  sampled at cmd_issue_i
- index_check_en_i  in  1  sampled at cmd_issue_i
- cmd_end_i  in  1  pulse: end bit of command driven
- abort_i  in  1  pulse: software reset of CMD circuit
- receiving_i  in  1  from receiver: start bit observed
- rsp_valid_i  in  1  from receiver: response finished
- rsp_end_bit_err_i  in  1  from receiver, valid with rsp_valid_i
- rsp_crc_corr_i  in  1  from receiver, valid with rsp_valid_i
- rsp_i  in  RspWidth  from receiver, valid with rsp_valid_i
- start_listening_o  out  1  to receiver
- long_rsp_o  out  1  to receiver
- timeout_o  out  1  to receiver and status: response timeout
- cmd_inhibit_o  out  1  high from cmd_issue_i until sequence ends
- rsp_o  out  RspWidth  latched payload
- rsp_wr_o  out  1  pulse: rsp_o updated
- cmd_complete_o  out  1  pulse
- crc_err_o, end_bit_err_o, index_err_o  out  1 each  pulses, coincident with cmd_complete_o

Behaviour:
- Reset: state IDLE. rsp_o=0. All pulses/levels low. Captured command fields =0.
- States: IDLE, WAIT_END, GAP, LISTEN, RECEIVE, REPORT.
- IDLE: on cmd_issue_i, capture type/index/check enables; go to WAIT_END. cmd_inhibit_o=1 in every state except IDLE.
- WAIT_END: on cmd_end_i:
  - type 00: go to REPORT with no errors.
  - otherwise: go to GAP.
- GAP: one clk_i cycle, then LISTEN. start_listening_o=1 only in the cycle GAP->LISTEN, i.e. the 2nd clk_i cycle after cmd_end_i.
- long_rsp_o = (captured type==01). Held stable from cmd_issue_i until return to IDLE.
- LISTEN:
  - Tick counter (8 bit) cleared on entry; increments on clk_en_i.
  - receiving_i=1 -> RECEIVE; counter frozen.
  - Counter reaching TimeoutTicks on a tick, with receiving_i low -> timeout_o=1 for exactly one clk_i cycle, then REPORT (timeout path).
  - Receiving wins if both occur in the same cycle: no timeout.
- RECEIVE: no timeout. On rsp_valid_i:
  - rsp_o<=rsp_i; rsp_wr_o=1 next cycle.
  - Latch crc_bad = crc_check_en & ~rsp_crc_corr_i.
  - Latch ebe = rsp_end_bit_err_i.
  - Latch idx_bad = index_check_en & (type!=01) & (rsp_i[37:32]!=cmd_index).
  - Go to REPORT.
- Payload layout:
  - 48-bit responses: index in rsp_i[37:32], argument in rsp_i[31:0], upper bits 0.
  - R2: rsp_i holds response bits [127:8].
- REPORT: single cycle, then IDLE.
  - cmd_complete_o=1 unless timeout.
  - crc_err_o/end_bit_err_o/index_err_o = latched flags; forced 0 on timeout.
  - rsp_wr_o coincides with REPORT.
- Type 11 is sequenced as 48-bit; busy on DAT0 is not handled here.
- abort_i in any state: go to IDLE next cycle.
  - If in LISTEN or RECEIVE, assert timeout_o for that one cycle so the receiver returns inactive.
  - No completion/error pulses. rsp_o unchanged.
- cmd_issue_i outside IDLE: ignored.
- cmd_end_i outside WAIT_END: ignored.
- rsp_valid_i outside RECEIVE: ignored.
- Async rst_i mid-sequence: immediate return to reset values.

Test Plan:
- 48-bit, index 17, checks on; receiver returns rsp_i[37:32]=17, crc ok, end bit ok -> start_listening_o 2 cycles after cmd_end_i; rsp_wr_o and cmd_complete_o coincide; no error pulses; rsp_o matches.
- R2; receiver returns rsp_i=120'hA5..5A with index field garbage -> long_rsp_o=1 throughout; index_err_o=0; rsp_o=rsp_i.
- 48-bit, receiving_i never asserted, TimeoutTicks=64 -> timeout_o after exactly 64 clk_en_i ticks, one cycle wide; cmd_complete_o=0; cmd_inhibit_o drops the cycle after REPORT.
- Receiver reports crc_corr=0, end_bit_err=1, index 18 vs 17: with crc_check_en=1 -> all three error pulses with cmd_complete_o; same with crc_check_en=0 -> crc_err_o=0.
- Type 00 -> start_listening_o never asserted; cmd_complete_o one cycle after REPORT entry following cmd_end_i.
- abort_i during LISTEN -> timeout_o one cycle; IDLE next; no cmd_complete_o; new cmd_issue_i accepted immediately after.
